// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    UPDATE,
    HALT
  } fetch_state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

endpackage

// File: rtl/fetch_decode.sv
// Combinational opcode decode of the held instruction word: halt, jump and jump target.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               is_halt,
  output logic               is_jmp,
  output logic [ADDR_W-1:0]  target
);

  logic [3:0] opcode;
  logic       unused_bits;

  assign opcode  = instr[OPC_MSB:OPC_LSB];
  assign is_halt = (opcode == OP_HALT);
  assign is_jmp  = (opcode == OP_JMP);
  assign target  = instr[ADDR_W-1:0];

  // Operand bits between the jump target and the opcode carry no meaning here.
  assign unused_bits = ^instr[OPC_LSB-1:ADDR_W];

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetch over req/ack, issue over valid/ready, then step or load the pc.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | mem_req high at mem_addr = pc_in, waiting for mem_ack
// ISSUE  | instr_valid high, waiting for instr_ready
// UPDATE | one cycle: INCR_PC or LOAD_PC pulse (none for HALT)
// HALT   | halted, left only by reset
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               INCR_PC,
  output logic               LOAD_PC,
  output logic [ADDR_W-1:0]  value,
  output logic               halted,
  output logic               fault
);

  fetch_state_t       state, state_nxt;
  logic               is_halt, is_jmp;
  logic [ADDR_W-1:0]  target;
  logic               timed_out;

  fetch_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr   (instr),
    .is_halt (is_halt),
    .is_jmp  (is_jmp),
    .target  (target)
  );

  // The pc only moves on the UPDATE pulse, so pc_in is stable for the whole fetch.
  assign mem_addr = pc_in;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state <= IDLE;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem_ack) instr <= mem_rdata;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] to_cnt;
  logic       fault_q;

  assign timed_out = (state == FETCH) && !mem_ack && (to_cnt == 4'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state != FETCH) to_cnt <= '0;
      else if (!mem_ack)  to_cnt <= to_cnt + 4'd1;
      if (timed_out) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  localparam int unused_timeout = TIMEOUT;

  assign timed_out = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH: begin
        if (mem_ack)        state_nxt = ISSUE;
        else if (timed_out) state_nxt = HALT;
      end
      ISSUE:  if (instr_ready) state_nxt = UPDATE;
      UPDATE: begin
        if (is_halt)  state_nxt = HALT;
        else if (run) state_nxt = FETCH;
        else          state_nxt = IDLE;
      end
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state == FETCH);
    instr_valid = (state == ISSUE);
    INCR_PC     = (state == UPDATE) && !is_halt && !is_jmp;
    LOAD_PC     = (state == UPDATE) && is_jmp;
    value       = LOAD_PC ? target : '0;
    halted      = (state == HALT);
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; the bench plays the pc register and the instruction ROM.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        run;
  logic [7:0]  pc_in;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        INCR_PC;
  logic        LOAD_PC;
  logic [7:0]  value;
  logic        halted;
  logic        fault;

  int nvec = 0;
  int nmis = 0;

  fetch_seq dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .run         (run),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .INCR_PC     (INCR_PC),
    .LOAD_PC     (LOAD_PC),
    .value       (value),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the bench's pc register follows the pulses seen before the edge.
  task automatic tick();
    logic       inc, ld;
    logic [7:0] v;
    inc = INCR_PC;
    ld  = LOAD_PC;
    v   = value;
    @(posedge clk);
    #1;
    if (RESET_N) begin
      if (inc)     pc_in = pc_in + 8'd1;
      else if (ld) pc_in = v;
    end
    #1;
  endtask

  // In FETCH: check the request, ack immediately with word, land in ISSUE.
  task automatic fetch_word(input string tag, input logic [7:0] addr, input logic [15:0] word);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".instr"}, 32'(instr), 32'(word));
    chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; run = 1'b0; pc_in = 8'h10;
    mem_ack = 1'b0; mem_rdata = 16'h0; instr_ready = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    chk("rst.req",    32'(mem_req),     32'd0);
    chk("rst.valid",  32'(instr_valid), 32'd0);
    chk("rst.instr",  32'(instr),       32'd0);
    chk("rst.pulses", 32'({INCR_PC, LOAD_PC}), 32'd0);
    chk("rst.value",  32'(value),       32'd0);
    chk("rst.halted", 32'(halted),      32'd0);
    chk("rst.fault",  32'(fault),       32'd0);

    // Reset in the middle of a fetch.
    run = 1'b1;
    tick();
    chk("midrst.req_before", 32'(mem_req), 32'd1);
    RESET_N = 1'b0; run = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    chk("midrst.req",    32'(mem_req), 32'd0);
    chk("midrst.pulses", 32'({INCR_PC, LOAD_PC, instr_valid}), 32'd0);
    chk("midrst.instr",  32'(instr), 32'd0);

    // Sequential fetch at 0x10.
    run = 1'b1; instr_ready = 1'b1;
    tick();
    fetch_word("seq", 8'h10, 16'h1234);
    tick();
    chk("seq.incr", 32'(INCR_PC), 32'd1);
    chk("seq.load", 32'(LOAD_PC), 32'd0);
    tick();
    chk("seq.incr_once", 32'(INCR_PC), 32'd0);

    // Jump to 0xA5.
    fetch_word("jmp", 8'h11, 16'hE0A5);
    tick();
    chk("jmp.load",  32'(LOAD_PC), 32'd1);
    chk("jmp.value", 32'(value),   32'hA5);
    chk("jmp.incr",  32'(INCR_PC), 32'd0);
    tick();
    chk("jmp.load_once", 32'(LOAD_PC), 32'd0);

    // Backpressure for five cycles.
    instr_ready = 1'b0;
    fetch_word("bp", 8'hA5, 16'h0777);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid",  32'(instr_valid), 32'd1);
      chk("bp.instr",  32'(instr), 32'h0777);
      chk("bp.pulses", 32'({INCR_PC, LOAD_PC}), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    chk("bp.still_valid", 32'(instr_valid), 32'd1);
    tick();
    chk("bp.incr", 32'(INCR_PC), 32'd1);
    tick();

    // Jump to 0xFF, then increment wraps to 0x00.
    fetch_word("j_ff", 8'hA6, 16'hE0FF);
    tick();
    chk("j_ff.value", 32'(value), 32'hFF);
    tick();
    fetch_word("wrap", 8'hFF, 16'h0001);
    tick();
    chk("wrap.incr", 32'(INCR_PC), 32'd1);
    tick();

    // Run dropped during ISSUE: finish through UPDATE, then IDLE.
    fetch_word("drop", 8'h00, 16'h0002);
    run = 1'b0; instr_ready = 1'b0;
    tick();
    chk("drop.valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    chk("drop.incr", 32'(INCR_PC), 32'd1);
    tick();
    chk("drop.idle_req", 32'(mem_req), 32'd0);
    chk("drop.pc", 32'(pc_in), 32'h01);
    tick();
    chk("drop.idle_req2", 32'(mem_req), 32'd0);

    // Halt.
    run = 1'b1;
    tick();
    fetch_word("halt", 8'h01, 16'hF000);
    tick();
    chk("halt.pulses", 32'({INCR_PC, LOAD_PC}), 32'd0);
    chk("halt.not_yet", 32'(halted), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.req", 32'(mem_req), 32'd0);
      tick();
    end

    // Fetch that is never acknowledged.
    RESET_N = 1'b0; run = 1'b0; pc_in = 8'h30;
    tick();
    RESET_N = 1'b1; run = 1'b1;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    chk("to.req_15th", 32'(mem_req), 32'd1);
    chk("to.fault_early", 32'(fault), 32'd0);
    tick();
    chk("to.fault",  32'(fault),   32'd1);
    chk("to.halted", 32'(halted),  32'd1);
    chk("to.req",    32'(mem_req), 32'd0);
    tick(); tick();
    chk("to.sticky", 32'(fault),   32'd1);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("noto.req",    32'(mem_req), 32'd1);
    chk("noto.fault",  32'(fault),   32'd0);
    chk("noto.halted", 32'(halted),  32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
